systolic_feeder: RTL and testbench

Drive-side sequencer for the 4x4 weight-stationary TPU array used by the brightness filter. It takes weight vectors and pixel vectors over valid/ready handshakes and produces the array's `control`, `wt_arr` and diagonally skewed `data_arr` stimulus. It sits directly upstream of the TPU and replaces hand-built skew patterns. Downstream consumers read the TPU outputs after `done`.

---
 rtl/systolic_feeder.sv | 178 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - weight/pixel sequencer with diagonal skew for a DEPTH x DEPTH systolic array (optional SYSTOLIC_FEEDER_LANE_VALID_EN adds lane_valid)
module systolic_feeder #(
    parameter int BIT_WIDTH    = 16,
    parameter int DEPTH        = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [15:0]                  num_vec,
    input  logic [BIT_WIDTH*DEPTH-1:0]   wt_in,
    input  logic                         wt_valid,
    output logic                         wt_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0]   vec_in,
    input  logic                         vec_valid,
    output logic                         vec_ready,
    output logic                         control,
    output logic [BIT_WIDTH*DEPTH-1:0]   wt_arr,
    output logic [BIT_WIDTH*DEPTH-1:0]   data_arr,
    output logic                         busy,
`ifdef SYSTOLIC_FEEDER_LANE_VALID_EN
    output logic [DEPTH-1:0]             lane_valid,
`endif
    output logic                         done
);

    localparam int W = BIT_WIDTH * DEPTH;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_WT, S_SETTLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t         r_state, w_next;
    logic [15:0]    r_num, r_cnt;
    logic           r_wt_ready, r_vec_ready, r_control, r_busy, r_done;
    logic [W-1:0]   r_wt_arr;
    logic           w_wt_acc, w_vec_acc, w_shift, w_cnt_en;
    logic [W-1:0]   w_in;

    // Handshakes are qualified by the registered ready, which is high only in the matching state
    assign w_wt_acc  = wt_valid & r_wt_ready;
    assign w_vec_acc = vec_valid & r_vec_ready;
    assign w_shift   = (r_state == S_FEED) || (r_state == S_FLUSH) || (r_state == S_DRAIN);
    // Bubbles, flush and drain all inject an all-zero vector
    assign w_in      = w_vec_acc ? vec_in : '0;

    assign wt_ready  = r_wt_ready;
    assign vec_ready = r_vec_ready;
    assign control   = r_control;
    assign wt_arr    = r_wt_arr;
    assign busy      = r_busy;
    assign done      = r_done;

    // Next-state decode; one shared counter tracks weights, vectors, flush and drain cycles
    always_comb begin
        w_next   = r_state;
        w_cnt_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD_WT;
            end
            S_LOAD_WT: begin
                if (w_wt_acc) begin
                    w_cnt_en = 1'b1;
                    if (r_cnt == 16'(DEPTH - 1)) w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_next = (r_num != 16'd0) ? S_FEED : S_DONE;
            end
            S_FEED: begin
                if (w_vec_acc) begin
                    w_cnt_en = 1'b1;
                    if (r_cnt == r_num - 16'd1) w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_cnt_en = 1'b1;
                if (r_cnt == 16'(DEPTH - 2)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_cnt_en = 1'b1;
                if (r_cnt == 16'(DRAIN_CYCLES - 1)) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register, job length latch and phase counter (cleared on every state change)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_num   <= 16'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) r_num <= num_vec;
            if (w_next != r_state)          r_cnt <= 16'd0;
            else if (w_cnt_en)              r_cnt <= r_cnt + 16'd1;
        end
    end

    // Registered status/handshake outputs follow the upcoming state; weight bus follows the current accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wt_ready  <= 1'b0;
            r_vec_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_control   <= 1'b0;
            r_wt_arr    <= '0;
        end else begin
            r_wt_ready  <= (w_next == S_LOAD_WT);
            r_vec_ready <= (w_next == S_FEED);
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
            r_control   <= (r_state == S_LOAD_WT);
            r_wt_arr    <= w_wt_acc ? wt_in : '0;
        end
    end

    // Skew network: lane i passes through i delay stages ahead of its output register
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
        logic [BIT_WIDTH-1:0] r_out;
        logic                 r_vout;

        if (gi == 0) begin : g_direct
            // Lane 0 goes straight to its output register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out  <= '0;
                    r_vout <= 1'b0;
                end else if (w_shift) begin
                    r_out  <= w_in[BIT_WIDTH-1:0];
                    r_vout <= w_vec_acc;
                end
            end
        end else begin : g_delay
            logic [BIT_WIDTH-1:0] r_dly  [gi];
            logic                 r_vdly [gi];

            // Lane gi shifts its word and accept flag through gi stages, then into the output register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < gi; j++) begin
                        r_dly[j]  <= '0;
                        r_vdly[j] <= 1'b0;
                    end
                    r_out  <= '0;
                    r_vout <= 1'b0;
                end else if (w_shift) begin
                    r_dly[0]  <= w_in[BIT_WIDTH*gi +: BIT_WIDTH];
                    r_vdly[0] <= w_vec_acc;
                    for (int j = 1; j < gi; j++) begin
                        r_dly[j]  <= r_dly[j-1];
                        r_vdly[j] <= r_vdly[j-1];
                    end
                    r_out  <= r_dly[gi-1];
                    r_vout <= r_vdly[gi-1];
                end
            end
        end

        assign data_arr[BIT_WIDTH*gi +: BIT_WIDTH] = r_out;
`ifdef SYSTOLIC_FEEDER_LANE_VALID_EN
        assign lane_valid[gi] = r_vout;
`else
        logic w_vout_unused;
        assign w_vout_unused = r_vout;
`endif
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder
module tb_systolic_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vec = 16'd0;
    logic [63:0] wt_in = '0;
    logic        wt_valid = 1'b0;
    logic        wt_ready;
    logic [63:0] vec_in = '0;
    logic        vec_valid = 1'b0;
    logic        vec_ready;
    logic        control;
    logic [63:0] wt_arr;
    logic [63:0] data_arr;
    logic        busy;
    logic        done;
`ifdef SYSTOLIC_FEEDER_LANE_VALID_EN
    logic [3:0]  lane_valid;
`endif

    systolic_feeder #(.BIT_WIDTH(16), .DEPTH(4), .DRAIN_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .wt_in(wt_in), .wt_valid(wt_valid), .wt_ready(wt_ready),
        .vec_in(vec_in), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .control(control), .wt_arr(wt_arr), .data_arr(data_arr),
        .busy(busy),
`ifdef SYSTOLIC_FEEDER_LANE_VALID_EN
        .lane_valid(lane_valid),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ctl;
        logic [63:0] wt;
        logic [63:0] data;
        logic        dn;
        logic [3:0]  lv;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [63:0] WTS [4] = '{64'h000a000000000000, 64'h0000000a00000000,
                                        64'h00000000000a0000, 64'h000000000000000a};
    localparam logic [63:0] ROWS_NS [7] = '{
        64'h0000_0000_0000_0000, 64'h0000_0000_0004_0001, 64'h0000_0008_0005_0002,
        64'h000c_0009_0006_0003, 64'h000d_000a_0007_0000, 64'h000e_000b_0000_0000,
        64'h000f_0000_0000_0000};
    localparam logic [3:0] LV_NS [7] = '{4'h1, 4'h3, 4'h7, 4'hf, 4'he, 4'hc, 4'h8};
    localparam logic [63:0] ROWS_ST [9] = '{
        64'h0000_0000_0000_0000, 64'h0000_0000_0004_0001, 64'h0000_0008_0005_0000,
        64'h000c_0009_0000_0000, 64'h000d_0000_0000_0002, 64'h0000_0000_0006_0003,
        64'h0000_000a_0007_0000, 64'h000e_000b_0000_0000, 64'h000f_0000_0000_0000};
    localparam logic [3:0] LV_ST [9] = '{4'h1, 4'h3, 4'h6, 4'hc, 4'h9, 4'h3, 4'h6, 4'hc, 4'h8};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
    endtask

    task automatic push(input logic c, input logic [63:0] w, input logic [63:0] d,
                        input logic dn, input logic [3:0] lv);
        exp_t e;
        e.ctl = c; e.wt = w; e.data = d; e.dn = dn; e.lv = lv;
        q.push_back(e);
    endtask

    // Expected per-cycle trace of a job, starting the cycle after start is sampled
    task automatic build_trace(input int n, input bit stall);
        push(1'b0, '0, '0, 1'b0, 4'h0);
        for (int k = 0; k < 4; k++) push(1'b1, WTS[k], '0, 1'b0, 4'h0);
        if (n == 0) begin
            push(1'b0, '0, '0, 1'b1, 4'h0);
        end else begin
            push(1'b0, '0, '0, 1'b0, 4'h0);
            if (stall) for (int i = 0; i < 9; i++) push(1'b0, '0, ROWS_ST[i], 1'b0, LV_ST[i]);
            else       for (int i = 0; i < 7; i++) push(1'b0, '0, ROWS_NS[i], 1'b0, LV_NS[i]);
            repeat (7) push(1'b0, '0, '0, 1'b0, 4'h0);
            push(1'b0, '0, '0, 1'b1, 4'h0);
        end
    endtask

    // Monitor: pops one expected record for every busy cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (q.size() == 0) begin
                    fail("trace_underrun");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("control", 64'(control), 64'(e.ctl));
                    chk("wt_arr", wt_arr, e.wt);
                    chk("data_arr", data_arr, e.data);
                    chk("done", 64'(done), 64'(e.dn));
`ifdef SYSTOLIC_FEEDER_LANE_VALID_EN
                    chk("lane_valid", 64'(lane_valid), 64'(e.lv));
`endif
                end
            end else begin
                chk("idle_done", 64'(done), 64'd0);
                chk("idle_data", data_arr, 64'd0);
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_control"}, 64'(control), 64'd0);
        chk({tag, "_wt_arr"}, wt_arr, 64'd0);
        chk({tag, "_data_arr"}, data_arr, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_wt_ready"}, 64'(wt_ready), 64'd0);
        chk({tag, "_vec_ready"}, 64'(vec_ready), 64'd0);
    endtask

    task automatic wait_accept(input bit is_wt, input string name);
        int t = 0;
        while (!(is_wt ? wt_ready : vec_ready) && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!(is_wt ? wt_ready : vec_ready)) fail(name);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input int n, input bit stall, input bit glitch, input bit abort);
        int t;
        build_trace(n, stall);
        @(posedge clk); #1;
        start = 1'b1; num_vec = 16'(n);
        @(posedge clk); #1;
        start = 1'b0; num_vec = 16'd0;
        for (int k = 0; k < 4; k++) begin
            wt_in = WTS[k]; wt_valid = 1'b1;
            wait_accept(1'b1, "wt_ready_timeout");
        end
        wt_valid = 1'b0; wt_in = '0;
        for (int k = 0; k < n; k++) begin
            if (stall && k == 2) begin
                vec_valid = 1'b0; vec_in = '0;
                repeat (2) begin @(posedge clk); #1; end
            end
            if (glitch && k == 2) start = 1'b1;
            vec_in = {16'(12 + k), 16'(8 + k), 16'(4 + k), 16'(k)};
            vec_valid = 1'b1;
            wait_accept(1'b0, "vec_ready_timeout");
            start = 1'b0;
            if (abort && k == 1) begin
                vec_valid = 1'b0; vec_in = '0;
                #2 rst = 1'b1;
                #1 check_zero_outputs("abort");
                q.delete();
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                repeat (3) @(posedge clk);
                return;
            end
        end
        vec_valid = 1'b0; vec_in = '0;
        t = 0;
        while (!done && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (!done) fail("done_timeout");
        @(negedge clk); #1;
        chk("trace_drained", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 check_zero_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        run_job(4, 1'b0, 1'b0, 1'b0);
        run_job(4, 1'b1, 1'b0, 1'b0);
        run_job(0, 1'b0, 1'b0, 1'b0);
        run_job(4, 1'b0, 1'b0, 1'b1);
        run_job(4, 1'b0, 1'b1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
